fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the processor control FSM. Holds the program counter and instruction register, reads 20-bit instructions from instruction memory over a valid-qualified read interface, and applies jumps requested by control. Presents a stable `instruction` word plus a valid flag to control, with retry/timeout recovery and a halt path driven by control's end-of-program signal.

## Interface
- `PC_W`, 6, program-counter / jump-address width (matches control's 6-bit jump target)
- `INSTR_W`, 20, instruction width
- `RESET_PC`, 0, boot address
- `TIMEOUT`, 8, cycles waited for `imem_valid` before reissuing a read (≥1)
- `MAX_RETRY`, 3, reissues allowed before declaring a fetch error (≥1)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `fetch_req`  in  1  control requests next instruction (single-cycle pulse)
- `jump_en`  in  1  with `fetch_req`: fetch from `jump_addr` instead of `pc+1`
- `jump_addr`  in  PC_W  jump target
- `halt`  in  1  end of program; level or pulse
- `imem_rd`  out  1  read strobe, one cycle per read attempt
- `imem_addr`  out  PC_W  read address
- `imem_rdata`  in  INSTR_W  read data, qualified by `imem_valid`
- `imem_valid`  in  1  read data valid
- `instruction`  out  INSTR_W  instruction register
- `instr_valid`  out  1  `instruction` is current and fetch complete
- `pc`  out  PC_W  address of the word in `instruction`
- `busy`  out  1  fetch in progress (state REQ or WAIT)
- `halted`  out  1  in HALTED state
- `fetch_err`  out  1  sticky: retries exhausted

## Operation
- States: BOOT, REQ, WAIT, IDLE, HALTED. Reset state BOOT.
- Reset values: `imem_rd`=0, `imem_addr`=RESET_PC, `instruction`=0, `instr_valid`=0, `pc`=RESET_PC, `busy`=0, `halted`=0, `fetch_err`=0; timeout and retry counters 0.
- BOOT: load fetch address = RESET_PC; next REQ.
- REQ: `imem_rd`=1 for exactly this cycle; clear timeout counter; next WAIT unless `imem_valid` accepted this cycle.
- WAIT: on `imem_valid`: `instruction`<=`imem_rdata`, `pc`<=fetch address, `instr_valid`<=1, retry<=0, next IDLE. Otherwise increment timeout; when it reaches TIMEOUT: if retry==MAX_RETRY → `fetch_err`<=1, HALTED; else retry++, back to REQ (same address).
- `imem_valid` is accepted in REQ or WAIT; ignored in all other states.
- IDLE: on `fetch_req`: fetch address = `jump_en` ? `jump_addr` : `pc`+1 (mod 2^PC_W, 2^PC_W−1 wraps to 0); `instr_valid`<=0; next REQ. `instruction` and `pc` keep old values until the new word lands.
- `fetch_req` outside IDLE is ignored (no queueing); `jump_en`/`jump_addr` are sampled only with an accepted `fetch_req`.
- `halt` has priority over everything: from any state next HALTED; `imem_rd` forced 0; any outstanding response discarded; `instruction`, `pc`, `instr_valid` frozen. HALTED exits only via `rst_n`.
- `fetch_err` clears only on reset.
- `imem_addr` = fetch address register; stable from REQ until the response or retry.

## Timing
- All state and outputs registered except `imem_rd`, `busy`, `halted` (decoded from state).
- `rst_n` low asynchronously forces reset values mid-fetch; release → BOOT next edge, REQ following edge (`imem_rd` high in 2nd cycle after release).
- Accepted `fetch_req` in cycle 0 → `instr_valid` low from cycle 1, `imem_rd` high cycle 1.
- Response with `imem_valid` in cycle N → `instruction`/`pc`/`instr_valid`=1 visible cycle N+1.
- Zero-wait memory (valid in REQ cycle): `fetch_req` cycle 0 → `instr_valid` cycle 2.
- Retry: TIMEOUT WAIT cycles without valid → REQ again; total error latency = (MAX_RETRY+1)·(1+TIMEOUT) cycles from first REQ.

## Test plan
- Reset release, memory returns 20'h4_1005 at addr 0 after 2 cycles → `imem_rd` at addr 0, then `instruction`=20'h41005, `pc`=0, `instr_valid`=1.
- From `pc`=5, `fetch_req` with `jump_en`=0 → read addr 6; with `jump_en`=1, `jump_addr`=6'd40 → read addr 40, `pc`=40. From `pc`=63, sequential → addr 0.
- Memory silent, TIMEOUT=8, MAX_RETRY=3 → four `imem_rd` pulses at identical address, 9 cycles apart; then `fetch_err`=1, `halted`=1, no further reads.
- `halt` asserted during WAIT, then `imem_valid` with 20'hFFFFF → `instruction` unchanged, `instr_valid` stays 0, `halted`=1; later `fetch_req` ignored.
- `fetch_req` pulsed during WAIT → ignored; only one read issued, single instruction update.
- `rst_n` dropped mid-WAIT → all outputs at reset values immediately; stale `imem_valid` ignored; boot fetch from RESET_PC restarts.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of the processor control FSM. Owns the
// program counter and the instruction register, reads instructions from
// instruction memory over a valid-qualified read port, applies jumps requested
// by control, and recovers from silent memory by reissuing reads a bounded
// number of times before flagging a sticky fetch error.
//
// Handshake: control pulses fetch_req for one cycle while instr_valid is high
// (IDLE); requests seen in any other state are dropped. Each read attempt is a
// single-cycle imem_rd strobe with imem_addr held stable until the response or
// the next retry. Memory answers with imem_valid/imem_rdata at any cycle from
// the strobe onward; a response is only taken while a read is outstanding.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   fetch_req                request next instruction (pulse)
//   jump_en, jump_addr       take jump_addr instead of pc+1 with fetch_req
//   halt                     end of program; enters HALTED from any state
//   imem_rd, imem_addr       read strobe and address to instruction memory
//   imem_rdata, imem_valid   read data and its qualifier
//   instruction, pc          instruction register and its address
//   instr_valid              instruction is current, fetch complete
//   busy, halted             decoded state flags
//   fetch_err                sticky: retries exhausted
//   state_dbg                current FSM state (BOOT=0 REQ=1 WAIT=2 IDLE=3 HALTED=4)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                PC_W      = 6,
    parameter int                INSTR_W   = 20,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter int                TIMEOUT   = 8,
    parameter int                MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic               halt,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               fetch_err,
    output logic [2:0]         state_dbg
);

    localparam int TO_W = (TIMEOUT   < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int RT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_IDLE   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t          state;
    logic [TO_W-1:0] timeout_cnt;
    logic [RT_W-1:0] retry_cnt;

    // imem_addr doubles as the fetch address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            imem_addr   <= RESET_PC;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= RESET_PC;
            fetch_err   <= 1'b0;
            timeout_cnt <= '0;
            retry_cnt   <= '0;
        end else if (halt) begin
            // Freeze everything; a response already in flight is dropped
            // because HALTED never looks at imem_valid.
            state <= S_HALTED;
        end else begin
            case (state)
                S_BOOT: begin
                    imem_addr <= RESET_PC;
                    state     <= S_REQ;
                end
                S_REQ: begin
                    timeout_cnt <= '0;
                    if (imem_valid) begin
                        // Zero-wait memory answered in the strobe cycle.
                        instruction <= imem_rdata;
                        pc          <= imem_addr;
                        instr_valid <= 1'b1;
                        retry_cnt   <= '0;
                        state       <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        pc          <= imem_addr;
                        instr_valid <= 1'b1;
                        retry_cnt   <= '0;
                        state       <= S_IDLE;
                    end else if (timeout_cnt == TO_W'(TIMEOUT - 1)) begin
                        // This cycle is the TIMEOUT-th silent WAIT cycle.
                        timeout_cnt <= '0;
                        if (retry_cnt == RT_W'(MAX_RETRY)) begin
                            fetch_err <= 1'b1;
                            state     <= S_HALTED;
                        end else begin
                            retry_cnt <= retry_cnt + RT_W'(1);
                            state     <= S_REQ;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                S_IDLE: begin
                    if (fetch_req) begin
                        // pc+1 wraps naturally at the register width.
                        imem_addr   <= jump_en ? jump_addr : (pc + PC_W'(1));
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

    // Strobe is masked by halt so no read escapes in the cycle halt arrives.
    assign imem_rd   = (state == S_REQ) && !halt;
    assign busy      = (state == S_REQ) || (state == S_WAIT);
    assign halted    = (state == S_HALTED);
    assign state_dbg = state;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so each tick() lands in the next clock cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 20;

    logic               clk;
    logic               rst_n;
    logic               fetch_req;
    logic               jump_en;
    logic [PC_W-1:0]    jump_addr;
    logic               halt;
    logic               imem_rd;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               halted;
    logic               fetch_err;
    logic [2:0]         state_dbg;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(6'd0), .TIMEOUT(8), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .jump_en(jump_en),
        .jump_addr(jump_addr), .halt(halt), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instruction(instruction),
        .instr_valid(instr_valid), .pc(pc), .busy(busy), .halted(halted),
        .fetch_err(fetch_err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = '0;
        halt       = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // Advance until imem_rd is high, at most 20 cycles.
    task automatic wait_rd(output bit found);
        int n;
        n = 0;
        while (imem_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        found = (imem_rd === 1'b1);
    endtask

    // Called in the REQ cycle: stay silent for 'delay' cycles, then answer.
    task automatic respond(input int delay, input logic [INSTR_W-1:0] data);
        for (int i = 0; i < delay; i++) tick();
        imem_valid = 1'b1;
        imem_rdata = data;
        tick();
        imem_valid = 1'b0;
        imem_rdata = '0;
    endtask

    // Called in IDLE: pulse fetch_req; returns in the following (REQ) cycle.
    task automatic fetch(input logic jmp, input logic [PC_W-1:0] addr);
        fetch_req = 1'b1;
        jump_en   = jmp;
        jump_addr = addr;
        tick();
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
    endtask

    task automatic boot(input logic [INSTR_W-1:0] data);
        bit found;
        do_reset();
        wait_rd(found);
        respond(0, data);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({imem_rd, busy, halted, fetch_err, instr_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got rd/busy/halted/err/iv=%b want 00000",
                     {imem_rd, busy, halted, fetch_err, instr_valid});
        end
        checks++;
        if (imem_addr !== 6'd0 || pc !== 6'd0 || instruction !== 20'h0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%0d pc=%0d instr=%h want 0 0 0",
                     imem_addr, pc, instruction);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0 (BOOT)", state_dbg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_boot();
        bit found;
        do_reset();
        wait_rd(found);
        checks++;
        if (!found || imem_addr !== 6'd0) begin
            errors++;
            $display("FAIL boot_read: got found=%0d addr=%0d want 1 0", found, imem_addr);
        end
        respond(2, 20'h41005);
        checks++;
        if (instruction !== 20'h41005 || pc !== 6'd0 || instr_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL boot_word: got instr=%h pc=%0d iv=%b busy=%b want 41005 0 1 0",
                     instruction, pc, instr_valid, busy);
        end
    endtask

    task automatic test_sequential();
        boot(20'h41005);
        fetch(1'b1, 6'd5);
        respond(1, 20'h00005);
        fetch(1'b0, 6'd33);    // jump_addr must be ignored without jump_en
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 6'd6 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_read: got rd=%b addr=%0d iv=%b want 1 6 0", imem_rd, imem_addr, instr_valid);
        end
        checks++;
        if (instruction !== 20'h00005 || pc !== 6'd5) begin
            errors++;
            $display("FAIL seq_hold: got instr=%h pc=%0d want 00005 5", instruction, pc);
        end
        respond(0, 20'h12345);  // zero-wait: valid two cycles after fetch_req
        checks++;
        if (instruction !== 20'h12345 || pc !== 6'd6 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_word: got instr=%h pc=%0d iv=%b want 12345 6 1", instruction, pc, instr_valid);
        end
        fetch(1'b1, 6'd40);
        checks++;
        if (imem_addr !== 6'd40) begin
            errors++;
            $display("FAIL jump_read: got addr=%0d want 40", imem_addr);
        end
        respond(3, 20'hABC40);
        checks++;
        if (pc !== 6'd40 || instruction !== 20'hABC40) begin
            errors++;
            $display("FAIL jump_word: got pc=%0d instr=%h want 40 abc40", pc, instruction);
        end
        fetch(1'b1, 6'd63);
        respond(0, 20'h0003F);
        fetch(1'b0, 6'd0);
        checks++;
        if (imem_addr !== 6'd0) begin
            errors++;
            $display("FAIL wrap_read: got addr=%0d want 0", imem_addr);
        end
        respond(1, 20'h55555);
        checks++;
        if (pc !== 6'd0 || instruction !== 20'h55555) begin
            errors++;
            $display("FAIL wrap_word: got pc=%0d instr=%h want 0 55555", pc, instruction);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        exp_q = '{8'd0, 8'd9, 8'd18, 8'd27};
        boot(20'h41005);
        fetch(1'b1, 6'd12);
        for (int c = 0; c < 45; c++) begin
            if (c > 0) tick();
            if (imem_rd === 1'b1) begin
                got_q.push_back(8'(c));
                checks++;
                if (imem_addr !== 6'd12) begin
                    errors++;
                    $display("FAIL retry_addr: cycle %0d got addr=%0d want 12", c, imem_addr);
                end
            end
            if (c == 35) begin
                checks++;
                if (fetch_err !== 1'b0 || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL err_early: cycle 35 got err=%b halted=%b want 0 0", fetch_err, halted);
                end
            end
            if (c == 36) begin
                checks++;
                if (fetch_err !== 1'b1 || halted !== 1'b1) begin
                    errors++;
                    $display("FAIL err_set: cycle 36 got err=%b halted=%b want 1 1", fetch_err, halted);
                end
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL retry_count: got %0d reads want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL retry_time: read %0d at cycle %0d want %0d", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 20'h41005) begin
            errors++;
            $display("FAIL err_hold: got iv=%b instr=%h want 0 41005", instr_valid, instruction);
        end
    endtask

    task automatic test_halt();
        int reads;
        boot(20'h41005);
        fetch(1'b0, 6'd0);
        tick();                 // now in WAIT
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: got halted=%b busy=%b rd=%b want 1 0 0", halted, busy, imem_rd);
        end
        imem_valid = 1'b1;
        imem_rdata = 20'hFFFFF;
        tick();
        imem_valid = 1'b0;
        checks++;
        if (instruction !== 20'h41005 || instr_valid !== 1'b0 || pc !== 6'd0) begin
            errors++;
            $display("FAIL halt_drop: got instr=%h iv=%b pc=%0d want 41005 0 0", instruction, instr_valid, pc);
        end
        reads = 0;
        fetch(1'b1, 6'd9);
        for (int i = 0; i < 5; i++) begin
            if (imem_rd === 1'b1) reads++;
            tick();
        end
        checks++;
        if (reads != 0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_stuck: got reads=%0d halted=%b want 0 1", reads, halted);
        end
    endtask

    task automatic test_req_in_wait();
        int reads;
        boot(20'h41005);
        fetch(1'b1, 6'd20);
        reads = 1;              // the strobe of this REQ cycle
        tick();                 // WAIT
        fetch_req = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 6'd50;
        tick();
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        if (imem_rd === 1'b1) reads++;
        tick();
        if (imem_rd === 1'b1) reads++;
        respond(0, 20'hABCDE);
        checks++;
        if (instruction !== 20'hABCDE || pc !== 6'd20 || imem_addr !== 6'd20) begin
            errors++;
            $display("FAIL wait_req_word: got instr=%h pc=%0d addr=%0d want abcde 20 20",
                     instruction, pc, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            if (imem_rd === 1'b1) reads++;
            tick();
        end
        checks++;
        if (reads != 1 || instr_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_req_ignored: got reads=%0d iv=%b busy=%b want 1 1 0", reads, instr_valid, busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        boot(20'h41005);
        fetch(1'b1, 6'd33);
        tick();                 // WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || imem_addr !== 6'd0 || instruction !== 20'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b addr=%0d instr=%h iv=%b want 0 0 0 0",
                     busy, imem_addr, instruction, instr_valid);
        end
        imem_valid = 1'b1;      // stale response arriving around reset
        imem_rdata = 20'h77777;
        tick();
        rst_n = 1'b1;           // BOOT this cycle
        tick();                 // REQ
        imem_valid = 1'b0;
        imem_rdata = '0;
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 6'd0 || instruction !== 20'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reboot_read: got rd=%b addr=%0d instr=%h iv=%b want 1 0 0 0",
                     imem_rd, imem_addr, instruction, instr_valid);
        end
        respond(1, 20'h2468A);
        checks++;
        if (instruction !== 20'h2468A || pc !== 6'd0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL reboot_word: got instr=%h pc=%0d iv=%b want 2468a 0 1", instruction, pc, instr_valid);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        test_reset();
        test_boot();
        test_sequential();
        test_timeout();
        test_halt();
        test_req_in_wait();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
